// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    // Overlap mode selectors for the detector's OVERLAP parameter
    localparam bit OVL_ON  = 1'b1;
    localparam bit OVL_OFF = 1'b0;

    // Default pattern geometry: four bits, first-received bit in the MSB
    localparam int                   PAT_W_DEF   = 4;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;

    // Increment that sticks at max_value instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [31:0] MAX_CNT = 32'({CNT_W{1'b1}});

    // Clear wins over increment; increment saturates at the all-ones value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), MAX_CNT));
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Moore serial bit-pattern detector with a loadable pattern, optional
// overlap, an input qualifier and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter bit               OVERLAP = OVL_ON,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x_in,
    input  logic             clear,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    localparam int              FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  history_shift;
    logic [FILL_W-1:0] fill_shift;
    logic              hit;
    logic              count_inc;

    logic [PAT_W-1:0]  history_next;
    logic [FILL_W-1:0] fill_next;
    logic              out_next;
    logic [PAT_W-1:0]  pattern_next;

    // Candidate state after absorbing x_in; a hit needs a completely filled history
    always_comb begin
        history_shift = {history[PAT_W-2:0], x_in};
        fill_shift    = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit           = (fill_shift == FILL_FULL) && (history_shift == pattern);
    end

    // Next-state selection with priority clear > pat_load > en
    always_comb begin
        history_next = history;
        fill_next    = fill;
        out_next     = 1'b0;
        pattern_next = pattern;
        count_inc    = 1'b0;
        if (clear) begin
            history_next = '0;
            fill_next    = '0;
        end else if (pat_load) begin
            pattern_next = pat_in;
            history_next = '0;
            fill_next    = '0;
        end else if (en) begin
            out_next  = hit;
            count_inc = hit;
            if (hit && (OVERLAP == OVL_OFF)) begin
                history_next = '0;
                fill_next    = '0;
            end else begin
                history_next = history_shift;
                fill_next    = fill_shift;
            end
        end
    end

    // State and registered match pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history <= '0;
            fill    <= '0;
            out     <= 1'b0;
            pattern <= PATTERN;
        end else begin
            history <= history_next;
            fill    <= fill_next;
            out     <= out_next;
            pattern <= pattern_next;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clear),
        .inc    (count_inc),
        .cnt    (match_count)
    );

endmodule
